// File: rtl/reflect_stream.sv
// Byte-serial word assembler with selectable bit/byte reflection ahead of the CRC datapath.
// Optional abort support is compiled in with `define REFLECT_STREAM_ABORT_EN.
module reflect_stream #(
  parameter int MAX_BYTES      = 8,
  parameter int MAX_BYTE_WIDTH = 3,
  parameter int MAX_BITS       = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [MAX_BYTE_WIDTH-1:0] cfg_bytewidth_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic                      in_valid_i,
  input  logic [7:0]                in_byte_i,
  output logic                      in_ready_o,
  output logic                      out_valid_o,
  output logic [MAX_BITS-1:0]       out_value_o,
  input  logic                      out_ready_i,
  input  logic                      abort_i
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  localparam logic [MAX_BYTE_WIDTH-1:0] MAX_W = MAX_BYTE_WIDTH'(MAX_BYTES - 1);

  state_e                    state_q, state_d;
  logic [MAX_BYTE_WIDTH-1:0] cnt_q, cnt_d;
  logic [MAX_BYTE_WIDTH-1:0] width_q, width_d;
  logic [1:0]                mode_q, mode_d;
  logic [MAX_BITS-1:0]       word_q, word_d;
  logic [MAX_BITS-1:0]       value_q, value_d;
  logic                      in_ready_q, out_valid_q;
  logic [MAX_BYTE_WIDTH-1:0] cfg_w;
  logic                      accept;

  function automatic logic [MAX_BITS-1:0] mask_word(input logic [MAX_BITS-1:0] v,
                                                     input logic [MAX_BYTE_WIDTH-1:0] w);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (k <= int'(w)) r[8*k +: 8] = v[8*k +: 8];
    end
    return r;
  endfunction

  function automatic logic [MAX_BITS-1:0] transform(input logic [MAX_BITS-1:0] v,
                                                     input logic [MAX_BYTE_WIDTH-1:0] w,
                                                     input logic [1:0] m);
    logic [MAX_BITS-1:0] vm;
    logic [MAX_BITS-1:0] r;
    vm = mask_word(v, w);
    r  = '0;
    case (m)
      2'd0: r = vm;
      2'd1: begin
        for (int k = 0; k < MAX_BYTES; k++)
          for (int b = 0; b < 8; b++) r[8*k + b] = vm[8*k + 7 - b];
      end
      2'd2: begin
        // Reverse the full register, then slide the active W bits back down to bit 0.
        for (int i = 0; i < MAX_BITS; i++) r[i] = vm[MAX_BITS-1-i];
        r = r >> (MAX_BITS - 8*(int'(w) + 1));
      end
      default: begin
        for (int k = 0; k < MAX_BYTES; k++)
          if (k <= int'(w)) r[8*(int'(w) - k) +: 8] = vm[8*k +: 8];
      end
    endcase
    return r;
  endfunction

  assign cfg_w  = (cfg_bytewidth_i > MAX_W) ? MAX_W : cfg_bytewidth_i;
  assign accept = in_valid_i && in_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    mode_d  = mode_q;
    word_d  = word_q;
    value_d = value_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          width_d = cfg_w;
          mode_d  = cfg_mode_i;
          word_d  = {{(MAX_BITS-8){1'b0}}, in_byte_i};
          if (cfg_w == '0) begin
            value_d = transform(word_d, cfg_w, cfg_mode_i);
            cnt_d   = '0;
            state_d = S_OUTPUT;
          end else begin
            cnt_d   = MAX_BYTE_WIDTH'(1);
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (accept) begin
          word_d[8*int'(cnt_q) +: 8] = in_byte_i;
          if (cnt_q == width_q) begin
            value_d = transform(word_d, width_q, mode_q);
            cnt_d   = '0;
            state_d = S_OUTPUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OUTPUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef REFLECT_STREAM_ABORT_EN
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      value_d = '0;
    end
`endif
  end

`ifndef REFLECT_STREAM_ABORT_EN
  logic unused_abort;
  assign unused_abort = abort_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      width_q     <= '0;
      mode_q      <= '0;
      value_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      width_q     <= width_d;
      mode_q      <= mode_d;
      value_q     <= value_d;
      in_ready_q  <= (state_d != S_OUTPUT);
      out_valid_q <= (state_d == S_OUTPUT);
    end
  end

  // Assembly buffer is pure data; bytes beyond the latched width are masked on output.
  always_ff @(posedge clk_i) begin
    word_q <= word_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_value_o = value_q;

endmodule
